// File: rtl/shift_sequencer.sv
// Command sequencer for a shifting PE array: issues row shifts, column shifts and a multiply
// (or a single clear), handshaking each command with the responders' ready lines and ack.
module shift_sequencer #(
  parameter int unsigned NUM_RESP = 4,
  parameter int unsigned SHIFT_W  = 6,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [2:0]  IDLE_CMD = 3'b000
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       clear,
  input  logic signed [SHIFT_W-1:0]  shift_x,
  input  logic signed [SHIFT_W-1:0]  shift_y,
  input  logic                       img_sel,
  input  logic [NUM_RESP-1:0]        ready,
  output logic [2:0]                 command_to_execute,
  output logic                       image_to_shift,
  output logic                       ack,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam logic [2:0] CmdMul   = 3'b000;
  localparam logic [2:0] CmdUp    = 3'b001;
  localparam logic [2:0] CmdDown  = 3'b010;
  localparam logic [2:0] CmdLeft  = 3'b011;
  localparam logic [2:0] CmdRight = 3'b100;
  localparam logic [2:0] CmdClear = 3'b111;
  localparam logic [15:0] TimeoutW = 16'(TIMEOUT);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StAck, StNext, StDone, StErr} state_e;

  state_e             state_q, state_d;
  logic [SHIFT_W-1:0] row_cnt_q, row_cnt_d;
  logic [SHIFT_W-1:0] col_cnt_q, col_cnt_d;
  logic               row_neg_q, row_neg_d;
  logic               col_neg_q, col_neg_d;
  logic               clr_q, clr_d;
  logic               last_q, last_d;
  logic               img_q, img_d;
  logic               err_q, err_d;
  logic [15:0]        wait_cnt_q, wait_cnt_d;
  logic [2:0]         cur_cmd;

  // Magnitude stays in SHIFT_W bits so the most negative offset maps to 2^(SHIFT_W-1).
  function automatic logic [SHIFT_W-1:0] mag(input logic [SHIFT_W-1:0] v);
    return v[SHIFT_W-1] ? ('0 - v) : v;
  endfunction

  always_comb begin
    cur_cmd = CmdMul;
    if (clr_q) begin
      cur_cmd = CmdClear;
    end else if (row_cnt_q != '0) begin
      cur_cmd = row_neg_q ? CmdUp : CmdDown;
    end else if (col_cnt_q != '0) begin
      cur_cmd = col_neg_q ? CmdLeft : CmdRight;
    end
  end

  always_comb begin
    state_d            = state_q;
    row_cnt_d          = row_cnt_q;
    col_cnt_d          = col_cnt_q;
    row_neg_d          = row_neg_q;
    col_neg_d          = col_neg_q;
    clr_d              = clr_q;
    last_d             = last_q;
    img_d              = img_q;
    err_d              = err_q;
    wait_cnt_d         = wait_cnt_q;
    command_to_execute = IDLE_CMD;
    ack                = 1'b0;
    done               = 1'b0;
    busy               = 1'b1;

    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start || clear) begin
          row_cnt_d = start ? mag(shift_y) : '0;
          col_cnt_d = start ? mag(shift_x) : '0;
          row_neg_d = shift_y[SHIFT_W-1];
          col_neg_d = shift_x[SHIFT_W-1];
          clr_d     = !start;
          last_d    = 1'b0;
          img_d     = img_sel;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        command_to_execute = cur_cmd;
        wait_cnt_d         = '0;
        state_d            = StWait;
        // The clear or the multiply is always the final command of a program.
        if (clr_q || (row_cnt_q == '0 && col_cnt_q == '0)) begin
          last_d = 1'b1;
        end else if (row_cnt_q != '0) begin
          row_cnt_d = row_cnt_q - 1'b1;
        end else begin
          col_cnt_d = col_cnt_q - 1'b1;
        end
      end
      StWait: begin
        wait_cnt_d = wait_cnt_q + 16'd1;
        if (&ready) begin
          state_d = StAck;
        end else if (wait_cnt_d == TimeoutW) begin
          state_d = StErr;
          err_d   = 1'b1;
        end
      end
      StAck: begin
        ack     = 1'b1;
        state_d = StNext;
      end
      StNext: begin
        state_d = last_q ? StDone : StIssue;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      StErr: begin
        state_d = StErr;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= StIdle;
      row_cnt_q  <= '0;
      col_cnt_q  <= '0;
      row_neg_q  <= 1'b0;
      col_neg_q  <= 1'b0;
      clr_q      <= 1'b0;
      last_q     <= 1'b0;
      img_q      <= 1'b0;
      err_q      <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      col_cnt_q  <= col_cnt_d;
      row_neg_q  <= row_neg_d;
      col_neg_q  <= col_neg_d;
      clr_q      <= clr_d;
      last_q     <= last_d;
      img_q      <= img_d;
      err_q      <= err_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign image_to_shift = img_q;
  assign err            = err_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: expected command streams are queued when a program is launched
// and popped by a monitor on each ack pulse.
module tb_shift_sequencer;

  localparam logic [2:0] IdleCmd = 3'b000;
  localparam int         Timeout = 255;

  logic              CLK = 1'b0;
  logic              reset;
  logic              start;
  logic              clear;
  logic signed [5:0] shift_x;
  logic signed [5:0] shift_y;
  logic              img_sel;
  logic [3:0]        ready;
  logic [2:0]        command_to_execute;
  logic              image_to_shift;
  logic              ack;
  logic              busy;
  logic              done;
  logic              err;

  int         checks = 0;
  int         errors = 0;
  int         ack_cnt = 0;
  int         done_cnt = 0;
  logic [2:0] sb_q[$];
  logic [2:0] pend;
  bit         have_pend = 1'b0;

  shift_sequencer dut (
    .CLK               (CLK),
    .reset             (reset),
    .start             (start),
    .clear             (clear),
    .shift_x           (shift_x),
    .shift_y           (shift_y),
    .img_sel           (img_sel),
    .ready             (ready),
    .command_to_execute(command_to_execute),
    .image_to_shift    (image_to_shift),
    .ack               (ack),
    .busy              (busy),
    .done              (done),
    .err               (err)
  );

  always #5 CLK = ~CLK;

  // Monitor: a non-idle code is latched as the pending command; an ack with nothing latched
  // means the multiply (000) was issued.
  always @(negedge CLK) begin
    logic [2:0] obs;
    logic [2:0] exp_cmd;
    if (reset === 1'b1) begin
      have_pend = 1'b0;
    end else begin
      if (done === 1'b1) done_cnt++;
      if (command_to_execute !== IdleCmd) begin
        if (have_pend) begin
          errors++;
          $display("FAIL cmd_held: command %b issued again before ack, required one cycle",
                   command_to_execute);
        end
        pend      = command_to_execute;
        have_pend = 1'b1;
      end
      if (ack === 1'b1) begin
        ack_cnt++;
        obs       = have_pend ? pend : 3'b000;
        have_pend = 1'b0;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack: ack for command %b, required no ack", obs);
        end else begin
          exp_cmd = sb_q.pop_front();
          if (obs !== exp_cmd) begin
            errors++;
            $display("FAIL cmd_order: got %b, required %b", obs, exp_cmd);
          end
        end
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    checks++;
    if (command_to_execute !== IdleCmd || ack !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        err !== 1'b0 || image_to_shift !== 1'b0) begin
      errors++;
      $display("FAIL %s: cmd=%b ack=%b busy=%b done=%b err=%b img=%b, required 000 0 0 0 0 0",
               name, command_to_execute, ack, busy, done, err, image_to_shift);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; clear = 1'b0; shift_x = '0; shift_y = '0;
    img_sel = 1'b0; ready = 4'hf;
    repeat (2) @(posedge CLK);
    #1 check_reset_outputs("reset_state");
    @(negedge CLK) reset = 1'b0;
  endtask

  task automatic run_prog(input string name, input bit do_start, input bit do_clear,
                          input logic signed [5:0] x, input logic signed [5:0] y,
                          input logic sel);
    int n;
    int k;
    int xi;
    int yi;
    xi = x;
    yi = y;
    if (do_start) begin
      for (int i = 0; i < (yi < 0 ? -yi : yi); i++) sb_q.push_back(yi < 0 ? 3'b001 : 3'b010);
      for (int i = 0; i < (xi < 0 ? -xi : xi); i++) sb_q.push_back(xi < 0 ? 3'b011 : 3'b100);
      sb_q.push_back(3'b000);
    end else begin
      sb_q.push_back(3'b111);
    end
    n = sb_q.size();
    ack_cnt = 0;
    done_cnt = 0;
    @(negedge CLK);
    start = do_start; clear = do_clear; shift_x = x; shift_y = y; img_sel = sel;
    @(posedge CLK);
    @(negedge CLK);
    // Scramble the sampled inputs to prove they were captured at launch.
    start = 1'b0; clear = 1'b0; shift_x = ~x; shift_y = ~y; img_sel = ~sel;
    k = 0;
    while (k < 4 * n + 20) begin
      @(posedge CLK);
      k++;
      #1;
      if (done === 1'b1) break;
    end
    checks++;
    if (k != 4 * n) begin
      errors++;
      $display("FAIL %s_latency: done after %0d cycles, required %0d", name, k, 4 * n);
    end
    checks++;
    if (image_to_shift !== sel) begin
      errors++;
      $display("FAIL %s_img: image_to_shift=%b, required %b", name, image_to_shift, sel);
    end
    @(posedge CLK);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy=%b done=%b, required 0 0", name, busy, done);
    end
    checks++;
    if (ack_cnt != n || done_cnt != 1 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_counts: acks=%0d dones=%0d left=%0d, required %0d 1 0",
               name, ack_cnt, done_cnt, sb_q.size(), n);
    end
    sb_q.delete();
  endtask

  task automatic test_reset_mid();
    int bad;
    ready = 4'h0;
    ack_cnt = 0;
    @(negedge CLK);
    start = 1'b1; shift_x = 6'sd3; shift_y = 6'sd0; img_sel = 1'b1;
    @(negedge CLK) start = 1'b0;
    repeat (2) @(negedge CLK);
    start = 1'b1; shift_x = -6'sd1;
    @(negedge CLK) start = 1'b0;
    checks++;
    if (busy !== 1'b1 || ack_cnt != 0) begin
      errors++;
      $display("FAIL mid_busy: busy=%b acks=%0d, required 1 0", busy, ack_cnt);
    end
    reset = 1'b1; ready = 4'hf;
    @(posedge CLK);
    #1 check_reset_outputs("mid_reset");
    @(negedge CLK) reset = 1'b0;
    bad = 0;
    repeat (12) begin
      @(posedge CLK);
      #1;
      if (command_to_execute !== IdleCmd || ack !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL dropped_start: %0d active cycles after reset, required 0", bad);
    end
  endtask

  task automatic test_timeout();
    int k;
    int bad;
    ready = 4'b1110;
    ack_cnt = 0;
    @(negedge CLK);
    start = 1'b1; shift_x = 6'sd1; shift_y = 6'sd0; img_sel = 1'b0;
    @(posedge CLK);
    @(negedge CLK) start = 1'b0;
    k = 0;
    while (k < Timeout + 20) begin
      @(posedge CLK);
      k++;
      #1;
      if (err === 1'b1) break;
    end
    checks++;
    if (k != Timeout + 1) begin
      errors++;
      $display("FAIL timeout_latency: err after %0d cycles, required %0d", k, Timeout + 1);
    end
    @(negedge CLK);
    start = 1'b1; clear = 1'b1;
    @(negedge CLK);
    start = 1'b0; clear = 1'b0;
    bad = 0;
    repeat (20) begin
      @(posedge CLK);
      #1;
      if (command_to_execute !== IdleCmd || ack !== 1'b0 || busy !== 1'b1 || err !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0 || ack_cnt != 0) begin
      errors++;
      $display("FAIL err_hold: %0d bad cycles, %0d acks, required 0 0", bad, ack_cnt);
    end
    @(negedge CLK) reset = 1'b1;
    ready = 4'hf;
    @(posedge CLK);
    #1 check_reset_outputs("err_reset");
    @(negedge CLK) reset = 1'b0;
    sb_q.delete();
  endtask

  initial begin
    test_reset();
    run_prog("mixed", 1'b1, 1'b0, 6'sd2, -6'sd1, 1'b0);
    run_prog("zero", 1'b1, 1'b0, 6'sd0, 6'sd0, 1'b0);
    run_prog("min_neg", 1'b1, 1'b0, -6'sd32, 6'sd0, 1'b0);
    run_prog("clear", 1'b0, 1'b1, 6'sd0, 6'sd0, 1'b1);
    // Back to back: start wins over a simultaneous clear, then an immediate relaunch.
    run_prog("start_wins", 1'b1, 1'b1, -6'sd1, 6'sd2, 1'b1);
    run_prog("b2b", 1'b1, 1'b0, 6'sd3, 6'sd1, 1'b0);
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_RESP, default 4, meaning the number of responders (array PEs, side registers) whose ready lines are collected.
REQ-002 The block SHALL have parameter SHIFT_W, default 6, meaning the width of the signed shift offsets.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles to wait for ready per command.
REQ-004 The block SHALL have parameter IDLE_CMD, default 3'b000, meaning the code driven whenever no command is being issued.
REQ-005 Ports, one per line, as name, direction, width, meaning:
- CLK  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that launches a shift-then-multiply program; ignored unless busy=0.
- clear  in  1  one-cycle pulse that launches a single reset (111) program; ignored unless busy=0; start wins if both are high.
- shift_x  in  SHIFT_W  signed column offset, sampled on start; positive = shift_right (100), negative = shift_left (011).
- shift_y  in  SHIFT_W  signed row offset, sampled on start; positive = shift_down (010), negative = shift_up (001).
- img_sel  in  1  sampled on start or clear; driven on image_to_shift.
- ready  in  NUM_RESP  per-responder ready.
- command_to_execute  out  3  command to all responders.
- image_to_shift  out  1  registered copy of img_sel.
- ack  out  1  one-cycle acknowledge to all responders.
- busy  out  1  high from the cycle after an accepted start/clear until done.
- done  out  1  one-cycle pulse when a program completes.
- err  out  1  sticky timeout flag.

Function
REQ-006 The state machine SHALL have states IDLE, ISSUE, WAIT, ACK, NEXT, DONE, and ERR.
REQ-007 In IDLE, an accepted start or clear SHALL load the sampled offsets, load img_sel, set busy, and go to ISSUE.
REQ-008 ISSUE SHALL drive the current command for exactly one cycle, then go to WAIT.
REQ-009 Responders execute on every non-ack cycle, so command_to_execute SHALL equal IDLE_CMD in every state except ISSUE.
REQ-010 WAIT SHALL hold until &ready is 1, then go to ACK; a 16-bit wait counter SHALL clear on entry and increment each WAIT cycle.
REQ-011 If the wait counter reaches TIMEOUT, the FSM SHALL go to ERR, set err, and not assert ack.
REQ-012 ACK SHALL assert ack for exactly one cycle, then go to NEXT.
REQ-013 NEXT SHALL select the next command in this order:
- |shift_y| row shifts first;
- then |shift_x| column shifts;
- then one multiply (000);
- then DONE.
REQ-014 Each issued shift SHALL decrement the remaining-row count (rows phase) or remaining-column count (columns phase).
REQ-015 A zero offset SHALL skip its phase, issuing zero commands for it.
REQ-016 A clear program SHALL issue a single 111 and then go to DONE, with no multiply.
REQ-017 Magnitudes SHALL be computed in SHIFT_W bits; the most negative offset, -2^(SHIFT_W-1), SHALL yield 2^(SHIFT_W-1) shifts, so the counters are SHIFT_W bits unsigned.
REQ-018 DONE SHALL pulse done for one cycle, clear busy, and return to IDLE.
REQ-019 ERR SHALL hold busy=1 and command_to_execute=IDLE_CMD until reset; start and clear SHALL be ignored in ERR.
REQ-020 start or clear arriving while busy=1 SHALL be dropped without effect.
REQ-021 Latency per command SHALL be 1 (ISSUE) + N_wait (>=1) + 1 (ACK) + 1 (NEXT) cycles.
REQ-022 Total program latency SHALL be the sum of the per-command latencies, plus 1 cycle for IDLE to ISSUE, plus 1 cycle for DONE.

Reset
REQ-023 reset SHALL take priority over all inputs and SHALL return the block to IDLE at the next edge, including mid-program and from ERR.
REQ-024 On reset, the outputs SHALL be:
- command_to_execute=IDLE_CMD;
- ack=0, busy=0, done=0, err=0;
- image_to_shift=0.
REQ-025 On reset, the offset and wait counters SHALL clear to 0.
REQ-026 Reset SHALL NOT itself issue the 111 command to responders; only a clear program does.

Verification
REQ-027 Test: start, shift_x=+2, shift_y=-1, img_sel=0, responders ready one cycle after each command -> commands issued in order 001,100,100,000; exactly 4 ack pulses; one done pulse; busy low afterwards.
REQ-028 Test: start, shift_x=0, shift_y=0 -> only 000 issued, then done.
REQ-029 Test: start, shift_x=-32 (SHIFT_W=6), shift_y=0 -> exactly 32 commands of 011, then 000.
REQ-030 Test: clear with img_sel=1 -> one 111 issued with image_to_shift=1, one ack, done, and no 000.
REQ-031 Test: one ready bit held at 0 -> err=1 after TIMEOUT WAIT cycles, no ack, and a later start is ignored; reset then clears err and busy.
REQ-032 Test: reset asserted in WAIT mid-program, and start pulsed during busy -> block returns to IDLE with all outputs at reset values, and the dropped start produces no extra commands.
